load_bus_master: RTL and testbench
==================================

LOAD_BUS_MASTER -- requirements
Module: load_bus_master

Interface
REQ-001 Parameter: ID, default 4'h0, AXI read ID driven on arid and expected on rid.
REQ-002 Parameter: MAX_LEN, default 16, maximum burst beats; ld_len above MAX_LEN-1 is clamped to MAX_LEN-1.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ld_valid  in  1  core load request.
REQ-006 ld_ready  out  1  request accepted when ld_valid & ld_ready.
REQ-007 ld_addr  in  32  load start address, byte address, word aligned.
REQ-008 ld_len  in  4  number of beats minus 1.
REQ-009 ld_rvalid  out  1  one returned beat valid.
REQ-010 ld_rdata  out  32  returned data.
REQ-011 ld_rlast  out  1  final beat of the transaction.
REQ-012 ld_err  out  1  error status, valid with ld_rlast.
REQ-013 bus_req  out  1  request to the load-bus arbiter.
REQ-014 bus_grnt  in  1  grant from the arbiter; may already be high before a request is made.
REQ-015 arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid  out  AXI AR channel; arready  in  1.
REQ-016 rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in  AXI R channel; rready  out  1.

Function
REQ-017 FSM states: IDLE, REQ, ADDR, DATA; all outputs are registered.
REQ-018 IDLE: ld_ready=1; on ld_valid, capture ld_addr and the clamped ld_len; set bus_req=1; go to REQ.
REQ-019 REQ: ld_ready=0; hold bus_req=1; in the first cycle with bus_grnt=1, set arvalid=1 and go to ADDR.
REQ-020 REQ: if bus_grnt=1 in the first REQ cycle, because the arbiter was already granting this master, arvalid rises on the next edge; no extra wait cycle is inserted.
REQ-021 ADDR: arvalid held at 1 with stable araddr=captured address, arlen={4'b0,len}, arsize=3'b010, arburst=2'b01, arid=ID.
REQ-022 ADDR: on arvalid & arready, clear arvalid, set rready=1, clear the beat counter and error flag, and go to DATA.
REQ-023 bus_req remains 1 from REQ entry through the last R beat, so the arbiter keeps ownership; bus_grnt is not re-checked after REQ.
REQ-024 DATA: rready=1; each rvalid & rready beat produces ld_rvalid=1 for exactly one cycle on the next edge.
REQ-025 DATA: the same edge drives ld_rdata=rdata and ld_rlast=rlast; the beat counter increments by 1 and is 5 bits wide.
REQ-026 Error flag sets, and stays set for the rest of the transaction, on any of: rresp != 2'b00, rid != ID, rlast on a beat count != len, or a beat at count == len without rlast.
REQ-027 ld_err is driven with the beat carrying ld_rlast, equal to the error flag including the current beat; ld_err=0 on all other beats.
REQ-028 DATA termination: only an rlast beat ends DATA; that edge clears rready and bus_req and returns the FSM to IDLE.
REQ-029 Extra beats beyond len are forwarded to the core, and the beat counter saturates at 31.
REQ-030 IDLE re-entry: ld_ready=1 in the cycle after the ld_rlast edge, so back-to-back requests are allowed; minimum issue-to-issue spacing is 4 cycles plus the bus wait.
REQ-031 rready is 0 in IDLE, REQ and ADDR; R beats offered in those states are not accepted.
REQ-032 ld_valid is ignored outside IDLE.

Reset
REQ-033 rst=1 forces, asynchronously: state=IDLE, ld_ready=0, bus_req=0, arvalid=0, rready=0, ld_rvalid=0, ld_rlast=0, ld_err=0, ld_rdata=0, araddr=0, arlen=0, counter=0.
REQ-034 ld_ready becomes 1 on the first edge after rst deasserts.
REQ-035 Reset mid-transaction abandons the transfer; no AXI recovery is attempted and the interconnect is reset together with this block.

Verification
REQ-036 Single beat: ld_addr=32'h1000_0040, ld_len=0, bus_grnt high, arready=1, rdata=32'hDEADBEEF with rlast -> araddr=32'h1000_0040 and arlen=0; then one ld_rvalid with ld_rdata=32'hDEADBEEF, ld_rlast=1, ld_err=0; then bus_req falls.
REQ-037 Grant wait: bus_grnt low for 5 cycles after bus_req rises -> arvalid stays 0 in those cycles and rises exactly 1 cycle after bus_grnt=1.
REQ-038 4-beat burst, ld_len=3, rvalid gaps of 2 cycles, rresp=2'b10 on beat 2 -> 4 ld_rvalid pulses; ld_err=1 only on beat 4; bus_req stays high throughout.
REQ-039 Early rlast on beat 2 of ld_len=3 -> transaction ends; ld_rlast=1 and ld_err=1 on beat 2; ld_ready=1 on the next cycle.
REQ-040 Bad rid: ID=4'h2, rid=4'h5 on a single beat -> ld_err=1.
REQ-041 Reset in DATA: rst asserted between beats -> all outputs 0 immediately without waiting for clk; a new request then completes normally.

Source files
------------

// File: rtl/load_bus_master.sv
// Load-bus master: turns one core load request into a single AXI read burst
// and streams the returned beats back to the core with an end-of-burst error status.
module load_bus_master #(
    parameter logic [3:0]  ID      = 4'h0,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_len,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        ld_rlast,
    output logic        ld_err,

    output logic        bus_req,
    input  logic        bus_grnt,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [2:0]       SIZE_4BYTE  = 3'b010;
    localparam logic [1:0]       BURST_INCR  = 2'b01;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   cnt;
    logic               err;

    logic [LEN_W-1:0]   len_clamped_c;
    logic               beat_c;
    logic               beat_err_c;
    logic               err_upd_c;

    // Requested length limited to what the burst engine supports
    generate
        if (MAX_LEN >= (1 << LEN_W)) begin : g_no_clamp
            assign len_clamped_c = ld_len;
        end else begin : g_clamp
            localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN - 1);
            assign len_clamped_c = (ld_len > LEN_MAX) ? LEN_MAX : ld_len;
        end
    endgenerate

    // Per-beat protocol checks; the running flag includes the current beat
    always_comb begin
        beat_c     = 1'b0;
        beat_err_c = 1'b0;
        err_upd_c  = err;
        if (state == DATA) begin
            beat_c = rvalid & rready;
        end
        beat_err_c = (rresp != RESP_OKAY)
                   | (rid != ID)
                   | ( rlast & (cnt != CNT_W'(len)))
                   | (~rlast & (cnt == CNT_W'(len)));
        err_upd_c  = err | beat_err_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            ld_ready  <= 1'b0;
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
            ld_rlast  <= 1'b0;
            ld_err    <= 1'b0;
            bus_req   <= 1'b0;
            arid      <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arburst   <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            ld_rvalid <= 1'b0;
            ld_rlast  <= 1'b0;
            ld_err    <= 1'b0;

            case (state)
                IDLE: begin
                    ld_ready <= 1'b1;
                    if (ld_valid && ld_ready) begin
                        ld_ready <= 1'b0;
                        bus_req  <= 1'b1;
                        len      <= len_clamped_c;
                        araddr   <= ADDR_W'(ld_addr);
                        arlen    <= {4'b0000, len_clamped_c};
                        arid     <= ID;
                        arsize   <= SIZE_4BYTE;
                        arburst  <= BURST_INCR;
                        state    <= REQ;
                    end
                end

                REQ: begin
                    if (bus_grnt) begin
                        arvalid <= 1'b1;
                        state   <= ADDR;
                    end
                end

                ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= '0;
                        err     <= 1'b0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    // Only rlast terminates; extra beats are still forwarded
                    if (beat_c) begin
                        ld_rvalid <= 1'b1;
                        ld_rdata  <= DATA_W'(rdata);
                        ld_rlast  <= rlast;
                        ld_err    <= rlast & err_upd_c;
                        err       <= err_upd_c;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (rlast) begin
                            rready   <= 1'b0;
                            bus_req  <= 1'b0;
                            ld_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_bus_master.sv
// Directed and randomized bench for load_bus_master with a transaction-level
// reference model for the burst length clamp and the end-of-burst error status.
module tb_load_bus_master;

    localparam logic [3:0]  TB_ID      = 4'h2;
    localparam int unsigned TB_MAX_LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [3:0]  ld_len;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_rlast;
    logic        ld_err;
    logic        bus_req;
    logic        bus_grnt;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    load_bus_master #(
        .ID      (TB_ID),
        .MAX_LEN (TB_MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_len    (ld_len),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .ld_rlast  (ld_rlast),
        .ld_err    (ld_err),
        .bus_req   (bus_req),
        .bus_grnt  (bus_grnt),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ld_ready"},  32'(ld_ready),  32'd0);
        check({tag, "_bus_req"},   32'(bus_req),   32'd0);
        check({tag, "_arvalid"},   32'(arvalid),   32'd0);
        check({tag, "_rready"},    32'(rready),    32'd0);
        check({tag, "_ld_rvalid"}, 32'(ld_rvalid), 32'd0);
        check({tag, "_ld_rlast"},  32'(ld_rlast),  32'd0);
        check({tag, "_ld_err"},    32'(ld_err),    32'd0);
        check({tag, "_ld_rdata"},  ld_rdata,       32'd0);
        check({tag, "_araddr"},    araddr,         32'd0);
        check({tag, "_arlen"},     32'(arlen),     32'd0);
    endtask

    // One full load transaction. resp_beat / rid_beat pick a beat to corrupt
    // (-1 for none); rst_after aborts with a reset right after that beat.
    task automatic txn(input logic [31:0] addr, input logic [3:0] len_in,
                       input int gdelay, input int nbeats, input int gap,
                       input int resp_beat, input int rid_beat,
                       input logic [31:0] d0, input int rst_after);
        int          len_cl;
        logic        exp_err;
        logic        last;
        logic [31:0] d;
        int          arwait;

        len_cl  = (int'(len_in) > int'(TB_MAX_LEN) - 1) ? int'(TB_MAX_LEN) - 1 : int'(len_in);
        exp_err = (resp_beat >= 0 && resp_beat < nbeats) ||
                  (rid_beat  >= 0 && rid_beat  < nbeats) ||
                  (nbeats != len_cl + 1);

        check("idle_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_len   = len_in;
        bus_grnt = (gdelay == 0);
        tick();
        ld_valid = 1'b0;
        ld_addr  = $urandom;
        ld_len   = 4'($urandom);
        check("req_bus_req",  32'(bus_req),  32'd1);
        check("req_ld_ready", 32'(ld_ready), 32'd0);
        check("req_arvalid",  32'(arvalid),  32'd0);

        // Stray R beats while waiting for the grant must be ignored
        for (int g = 0; g < gdelay; g++) begin
            rvalid = 1'b1;
            rlast  = 1'b1;
            ld_valid = 1'b1;
            tick();
            check("wait_arvalid",   32'(arvalid),   32'd0);
            check("wait_rready",    32'(rready),    32'd0);
            check("wait_ld_rvalid", 32'(ld_rvalid), 32'd0);
        end
        ld_valid = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        bus_grnt = 1'b1;
        tick();
        check("ar_arvalid", 32'(arvalid), 32'd1);
        check("ar_araddr",  araddr,       addr);
        check("ar_arlen",   32'(arlen),   32'(len_cl));
        check("ar_arsize",  32'(arsize),  32'd2);
        check("ar_arburst", 32'(arburst), 32'd1);
        check("ar_arid",    32'(arid),    32'(TB_ID));

        arwait = $urandom_range(0, 2);
        for (int w = 0; w < arwait; w++) begin
            bus_grnt = 1'($urandom);
            tick();
            check("arhold_arvalid", 32'(arvalid), 32'd1);
            check("arhold_araddr",  araddr,       addr);
        end
        arready = 1'b1;
        tick();
        arready  = 1'b0;
        bus_grnt = 1'($urandom);
        check("data_arvalid", 32'(arvalid), 32'd0);
        check("data_rready",  32'(rready),  32'd1);

        for (int i = 0; i < nbeats; i++) begin
            for (int gp = 0; gp < gap; gp++) begin
                tick();
                check("gap_ld_rvalid", 32'(ld_rvalid), 32'd0);
                check("gap_bus_req",   32'(bus_req),   32'd1);
            end
            last   = (i == nbeats - 1);
            d      = (i == 0) ? d0 : ($urandom | 32'd1);
            rvalid = 1'b1;
            rdata  = d;
            rresp  = (i == resp_beat) ? 2'b10 : 2'b00;
            rid    = (i == rid_beat) ? 4'h5 : TB_ID;
            rlast  = last;
            tick();
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            rid    = TB_ID;
            check("beat_ld_rvalid", 32'(ld_rvalid), 32'd1);
            check("beat_ld_rdata",  ld_rdata,       d);
            check("beat_ld_rlast",  32'(ld_rlast),  32'(last));
            check("beat_ld_err",    32'(ld_err),    32'(last & exp_err));
            if (last) begin
                check("end_bus_req",  32'(bus_req),  32'd0);
                check("end_ld_ready", 32'(ld_ready), 32'd1);
                check("end_rready",   32'(rready),   32'd0);
            end else begin
                check("mid_bus_req",  32'(bus_req),  32'd1);
            end
            if (i == rst_after) begin
                rst = 1'b1;
                #1;
                check_all_zero("midrst");
                tick();
                rst = 1'b0;
                check("postrst_ld_ready_lo", 32'(ld_ready), 32'd0);
                tick();
                check("postrst_ld_ready_hi", 32'(ld_ready), 32'd1);
                bus_grnt = 1'b0;
                return;
            end
        end
        bus_grnt = 1'b0;
    endtask

    initial begin
        int len_r;
        int lc;
        int nb;
        int rb;
        int ib;

        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_len   = '0;
        bus_grnt = 1'b0;
        arready  = 1'b0;
        rid      = TB_ID;
        rdata    = '0;
        rresp    = 2'b00;
        rlast    = 1'b0;
        rvalid   = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        check("rst_rel_ld_ready_lo", 32'(ld_ready), 32'd0);
        tick();
        check("rst_rel_ld_ready_hi", 32'(ld_ready), 32'd1);

        // Single beat with grant already high
        txn(32'h1000_0040, 4'd0, 0, 1, 0, -1, -1, 32'hDEAD_BEEF, -1);
        // Grant delayed five cycles
        txn(32'h2000_0100, 4'd1, 5, 2, 0, -1, -1, 32'h1234_5678, -1);
        // Four beats, gaps of two, SLVERR on beat 2
        txn(32'h3000_0000, 4'd3, 1, 4, 2, 1, -1, 32'hA5A5_0001, -1);
        // Early rlast on beat 2 of four
        txn(32'h3000_0200, 4'd3, 0, 2, 0, -1, -1, 32'h0BAD_0002, -1);
        // Wrong rid on a single beat
        txn(32'h4000_0000, 4'd0, 0, 1, 0, -1, 0, 32'hC0DE_0003, -1);
        // Over-long request is clamped
        txn(32'h5000_0000, 4'd15, 2, 8, 0, -1, -1, 32'h5555_0004, -1);
        // Beats beyond len are forwarded and flagged
        txn(32'h6000_0000, 4'd1, 0, 4, 1, -1, -1, 32'h6666_0005, -1);
        // Reset between beats, then a clean transaction
        txn(32'h7000_0000, 4'd3, 0, 4, 1, -1, -1, 32'h7777_0006, 1);
        txn(32'h7000_0040, 4'd2, 1, 3, 0, -1, -1, 32'h7777_0007, -1);

        for (int t = 0; t < 25; t++) begin
            len_r = $urandom_range(0, 15);
            lc    = (len_r > int'(TB_MAX_LEN) - 1) ? int'(TB_MAX_LEN) - 1 : len_r;
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(1, lc + 1);
                1:       nb = lc + 2;
                default: nb = lc + 1;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
            ib = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb - 1) : -1;
            txn({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 4'(len_r),
                $urandom_range(0, 3), nb, $urandom_range(0, 2), rb, ib,
                $urandom | 32'd1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
